// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and limits for the UART transmit arbiter
package uart_pkg;
  localparam int UART_NREQ_MAX = 8;
  localparam int UART_TRIG_LOW_MIN = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT
  } uart_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);
  localparam int PW = $clog2(NREQ);
  int idx;
  // scan from the farthest offset down so the closest valid requester to ptr wins
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    idx = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: frame-level round-robin arbiter feeding one byte transmitter; UART_TX_ARB_TIMEOUT_EN adds a watchdog
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TRIG_LOW = 4,
  parameter int TIMEOUT  = 1_000_000
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_int,
  input  logic              tx_busy,
  output logic              arb_busy,
  output logic              timeout_err
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TRIG_LOW);
  if (NREQ < 2 || NREQ > UART_NREQ_MAX || TRIG_LOW < UART_TRIG_LOW_MIN || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arb: parameter out of range");
  end
  uart_arb_state_t state, state_nx;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx, owner, ptr, owner_inc;
  logic [TW-1:0]   trig_cnt;
  logic            last_r, busy, abort;
  assign busy = (tx_busy == 1'b1);
  assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic          in_wait;
  assign in_wait = state inside {S_WAIT_BUSY, S_WAIT_DONE, S_NEXT};
  assign abort = in_wait && wd_cnt == WW'(TIMEOUT - 1);
  // watchdog restarts on every entry to a waiting state and counts while it stays there
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= (state_nx != state || !in_wait) ? '0 : wd_cnt + 1'b1;
      timeout_err <= abort;
    end
  end
`else
  assign abort = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  end
  // next-state logic; a watchdog abort overrides everything
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = |req_valid ? S_LOAD : S_IDLE;
      S_LOAD:      state_nx = S_TRIG;
      S_TRIG:      state_nx = (trig_cnt == TW'(TRIG_LOW - 1)) ? S_WAIT_BUSY : S_TRIG;
      S_WAIT_BUSY: state_nx = busy ? S_WAIT_DONE : S_WAIT_BUSY;
      S_WAIT_DONE: state_nx = busy ? S_WAIT_DONE : (last_r ? S_IDLE : S_NEXT);
      S_NEXT:      state_nx = req_valid[owner] ? S_LOAD : S_NEXT;
      default:     state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end
  // registered datapath; tx_int comes from a flop so state decode can never glitch a falling edge
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      owner <= '0;
      ptr <= '0;
      last_r <= 1'b0;
      tx_data <= 8'h00;
      tx_int <= 1'b1;
      trig_cnt <= '0;
    end else begin
      tx_int <= state_nx != S_TRIG;
      trig_cnt <= (state == S_TRIG) ? trig_cnt + 1'b1 : '0;
      if (state == S_IDLE && |req_valid) begin
        grant <= arb_gnt;
        owner <= arb_idx;
      end
      if (state == S_LOAD) begin
        tx_data <= req_data[8*int'(owner) +: 8];
        last_r <= req_last[owner];
      end
      if (abort || (state == S_WAIT_DONE && !busy && last_r)) begin
        grant <= '0;
        ptr <= owner_inc;
      end
    end
  end
  // outputs decoded from the current state
  always_comb begin
    req_ready = (state == S_LOAD) ? grant : '0;
    arb_busy = state != S_IDLE;
  end
endmodule
